// File: rtl/dual_ram_be.sv
// rtl/dual_ram_be.sv - byte-strobed 1W/1R RAM with write-first reads, optional output stage and zero-fill.
module dual_ram_be #(
  parameter int DW         = 32,
  parameter int AW         = 12,
  parameter int MEM_NUM    = 4096,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_en_i,
  input  logic [AW-1:0]   w_addr_i,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_strb_i,
  input  logic            r_en_i,
  input  logic [AW-1:0]   r_addr_i,
  output logic [DW-1:0]   r_data_o,
  output logic            r_valid_o,
  output logic            busy_o
);

  localparam int NB = DW / 8;
  // One extra bit so MEM_NUM == 2**AW still compares correctly.
  localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_NUM);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q;
  logic [DW-1:0] mem [0:MEM_NUM-1];
  logic          clear_last;
  logic          w_ok;
  logic          r_accept;
  logic          r_in_range;
  logic [DW-1:0] rd_merge;
  logic          rd_v1_q;
  logic [DW-1:0] rd_d1_q;

  assign clear_last = (clr_cnt_q == AW'(MEM_NUM - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLR_ON_RST != 0) ? CLEAR : RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clear_last) begin
      state_d = RUN;
    end
  end

  always_comb begin
    busy_o     = (state_q == CLEAR);
    w_ok       = (state_q == RUN) && w_en_i && ({1'b0, w_addr_i} < MEM_LIM);
    r_accept   = (state_q == RUN) && r_en_i;
    r_in_range = ({1'b0, r_addr_i} < MEM_LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state_q != CLEAR) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else if (w_ok) begin
        for (int k = 0; k < NB; k++) begin
          if (w_strb_i[k]) begin
            mem[w_addr_i][8*k +: 8] <= w_data_i[8*k +: 8];
          end
        end
      end
    end
  end

  // Write-first: same-cycle write bytes override the stored bytes.
  always_comb begin
    rd_merge = '0;
    if (r_in_range) begin
      rd_merge = mem[r_addr_i];
      for (int k = 0; k < NB; k++) begin
        if (w_ok && w_addr_i == r_addr_i && w_strb_i[k]) begin
          rd_merge[8*k +: 8] = w_data_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
    end else begin
      rd_v1_q <= r_accept;
      if (r_accept) begin
        rd_d1_q <= rd_merge;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          rd_v2_q;
      logic [DW-1:0] rd_d2_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_v2_q <= 1'b0;
          rd_d2_q <= '0;
        end else begin
          rd_v2_q <= rd_v1_q;
          if (rd_v1_q) begin
            rd_d2_q <= rd_d1_q;
          end
        end
      end

      assign r_valid_o = rd_v2_q;
      assign r_data_o  = rd_d2_q;
    end else begin : g_no_out_reg
      assign r_valid_o = rd_v1_q;
      assign r_data_o  = rd_d1_q;
    end
  endgenerate

endmodule

// File: tb/tb_dual_ram_be.sv
// tb/tb_dual_ram_be.sv - directed bench for dual_ram_be with 1-cycle/clear and 2-cycle/no-clear instances.
module tb_dual_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_en;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        r_en;
  logic [3:0]  r_addr;
  logic [31:0] r_data_a, r_data_b;
  logic        r_valid_a, r_valid_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_ram_be #(.DW(32), .AW(4), .MEM_NUM(12), .OUT_REG(0), .CLR_ON_RST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_strb_i(w_strb), .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(r_data_a),
    .r_valid_o(r_valid_a), .busy_o(busy_a)
  );

  dual_ram_be #(.DW(32), .AW(4), .MEM_NUM(12), .OUT_REG(1), .CLR_ON_RST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_strb_i(w_strb), .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(r_data_b),
    .r_valid_o(r_valid_b), .busy_o(busy_b)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [16];
  logic [31:0] exp_mem [12];
  logic [31:0] vals [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic re, input logic [3:0] ra);
    w_en = we; w_addr = wa; w_data = wd; w_strb = ws; r_en = re; r_addr = ra;
  endtask

  task automatic count_busy(input string name);
    int cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk(name, 32'(cnt), 32'd12);
  endtask

  initial begin
    logic [31:0] last_a, last_b, pexp, ea, eb;
    logic        pv;

    vt[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  32'h0};
    vt[1]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'hDEADBEEF};
    vt[2]  = '{1'b1, 4'd5,  32'h11223344, 4'hF, 1'b0, 4'd0,  32'h0};
    vt[3]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'h5, 1'b1, 4'd5,  32'h11BB33DD};
    vt[4]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  32'h11BB33DD};
    vt[5]  = '{1'b1, 4'd13, 32'h12345678, 4'hF, 1'b1, 4'd13, 32'h0};
    vt[6]  = '{1'b1, 4'd0,  32'hA5A5A5A5, 4'h0, 1'b1, 4'd3,  32'hDEADBEEF};
    vt[7]  = '{1'b1, 4'd7,  32'hCAFEF00D, 4'hF, 1'b0, 4'd0,  32'h0};
    vt[8]  = '{1'b1, 4'd7,  32'h77000000, 4'h8, 1'b1, 4'd7,  32'h77FEF00D};
    vt[9]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd7,  32'h77FEF00D};
    vt[10] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  32'h0};
    vt[11] = '{1'b1, 4'd9,  32'h01020304, 4'hF, 1'b1, 4'd9,  32'h01020304};
    vt[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd12, 32'h0};
    vt[13] = '{1'b1, 4'd11, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd11, 32'hFFFFFFFF};
    vt[14] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd11, 32'hFFFFFFFF};
    vt[15] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  32'h0};

    foreach (exp_mem[i]) exp_mem[i] = 32'h0;
    exp_mem[3]  = 32'hDEADBEEF;
    exp_mem[5]  = 32'h11BB33DD;
    exp_mem[7]  = 32'h77FEF00D;
    exp_mem[9]  = 32'h01020304;
    exp_mem[11] = 32'hFFFFFFFF;
    vals[0] = 32'h10101010; vals[1] = 32'h20202020; vals[2] = 32'h30303030;

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    chk("rst_valid_a", 32'(r_valid_a), 32'd0);
    chk("rst_data_a", r_data_a, 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_valid_b", 32'(r_valid_b), 32'd0);
    chk("rst_data_b", r_data_b, 32'h0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);

    rst_n = 1'b1;
    count_busy("clear_cycles");
    chk("busy_b_run", 32'(busy_b), 32'd0);

    last_a = 32'h0; last_b = 32'h0; pv = 1'b0; pexp = 32'h0;
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ws, vt[i].re, vt[i].ra);
      @(negedge clk);
      ea = vt[i].re ? vt[i].exp : last_a;
      chk($sformatf("vec%0d_valid_a", i), 32'(r_valid_a), 32'(vt[i].re));
      chk($sformatf("vec%0d_data_a", i), r_data_a, ea);
      last_a = ea;
      eb = pv ? pexp : last_b;
      chk($sformatf("vec%0d_valid_b", i), 32'(r_valid_b), 32'(pv));
      chk($sformatf("vec%0d_data_b", i), r_data_b, eb);
      last_b = eb;
      pv = vt[i].re;
      pexp = vt[i].exp;
    end

    for (int a = 0; a < 12; a++) begin
      drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a));
      @(negedge clk);
      chk($sformatf("sweep%0d_valid", a), 32'(r_valid_a), 32'd1);
      chk($sformatf("sweep%0d_data", a), r_data_a, exp_mem[a]);
    end
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    @(negedge clk);
    chk("hold_valid_a", 32'(r_valid_a), 32'd0);
    chk("hold_data_a", r_data_a, exp_mem[11]);
    @(negedge clk);

    for (int a = 0; a < 3; a++) begin
      drive(1'b1, 4'(a), vals[a], 4'hF, 1'b0, 4'd0);
      @(negedge clk);
    end
    for (int s = 0; s < 5; s++) begin
      drive(1'b0, 4'd0, 32'h0, 4'h0, (s < 3), 4'(s));
      @(negedge clk);
      chk($sformatf("pipe%0d_valid_b", s), 32'(r_valid_b), 32'(s >= 1 && s <= 3));
      if (s >= 1 && s <= 3) chk($sformatf("pipe%0d_data_b", s), r_data_b, vals[s-1]);
    end

    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
    @(negedge clk);
    chk("pre_rst_valid_a", 32'(r_valid_a), 32'd1);
    chk("pre_rst_data_a", r_data_a, 32'hDEADBEEF);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("inflight_valid_b", 32'(r_valid_b), 32'd0);
    chk("inflight_data_b", r_data_b, 32'h0);
    chk("rst2_valid_a", 32'(r_valid_a), 32'd0);
    chk("rst2_data_a", r_data_a, 32'h0);
    @(negedge clk);
    chk("rst2_valid_b", 32'(r_valid_b), 32'd0);
    rst_n = 1'b1;
    count_busy("reclear_cycles");

    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
    @(negedge clk);
    chk("post_clear_valid_a", 32'(r_valid_a), 32'd1);
    chk("post_clear_data_a", r_data_a, 32'h0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    @(negedge clk);
    chk("keep_valid_b", 32'(r_valid_b), 32'd1);
    chk("keep_data_b", r_data_b, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_ram_be.md
DUAL_RAM_BE -- requirements
Module: dual_ram_be

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter AW, default 12: address width in bits.
REQ-003 SHALL have parameter MEM_NUM, default 4096: number of words, at most 2**AW.
REQ-004 SHALL have parameter OUT_REG, default 0: 0 gives 1-cycle read latency, 1 gives 2-cycle read latency through an added output register.
REQ-005 SHALL have parameter CLR_ON_RST, default 0: 1 zero-fills the whole memory after reset.
REQ-006 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port w_en_i, input, 1 bit: write request.
REQ-009 SHALL have port w_addr_i, input, AW bits: write address.
REQ-010 SHALL have port w_data_i, input, DW bits: write data.
REQ-011 SHALL have port w_strb_i, input, DW/8 bits: byte write enables; bit k covers w_data_i[8k+7:8k].
REQ-012 SHALL have port r_en_i, input, 1 bit: read request.
REQ-013 SHALL have port r_addr_i, input, AW bits: read address.
REQ-014 SHALL have port r_data_o, output, DW bits: read data.
REQ-015 SHALL have port r_valid_o, output, 1 bit: one-cycle pulse marking r_data_o as the answer to a read request.
REQ-016 SHALL have port busy_o, output, 1 bit: high while the memory is being cleared; requests are ignored while it is high.

Function
REQ-017 SHALL use a two-state FSM, CLEAR and RUN.
REQ-018 CLEAR: a counter walks from 0 to MEM_NUM-1, writing all-zero words one per cycle; after writing MEM_NUM-1 the FSM goes to RUN in the next cycle.
REQ-019 In CLEAR, w_en_i and r_en_i SHALL be ignored, busy_o SHALL be 1 and r_valid_o SHALL be 0.
REQ-020 In RUN, when w_en_i=1 and w_addr_i<MEM_NUM, each byte with w_strb_i[k]=1 SHALL update at the clock edge; bytes with strobe 0 SHALL keep their value.
REQ-021 A write with w_strb_i all zero, or with w_addr_i>=MEM_NUM, SHALL leave the memory unchanged.
REQ-022 A read accepted in cycle N (RUN, r_en_i=1) SHALL drive r_data_o and pulse r_valid_o in cycle N+1 when OUT_REG=0, or in cycle N+2 when OUT_REG=1.
REQ-023 Reads SHALL be write-first: if in cycle N w_en_i=1 and w_addr_i==r_addr_i<MEM_NUM, each returned byte SHALL be the new w_data_i byte where the strobe is 1, and the old memory byte where it is 0.
REQ-024 A read in cycle N SHALL see all writes completed at or before cycle N, including a write in cycle N-1 to the same address.
REQ-025 A read with r_addr_i>=MEM_NUM SHALL return all zeros and still pulse r_valid_o.
REQ-026 r_data_o SHALL hold its last value when no read completes; r_valid_o SHALL be 0 in those cycles.
REQ-027 Back-to-back reads SHALL be accepted every cycle, giving full throughput and in-order results, for both values of OUT_REG.
REQ-028 With OUT_REG=1, both pipeline stages SHALL carry their own valid bit, and no result SHALL be dropped or duplicated.

Reset
REQ-029 While rst_n=0 at a clock edge: r_data_o SHALL be 0, r_valid_o 0, pipeline valid bits 0, clear counter 0.
REQ-030 While rst_n=0 at a clock edge, the FSM SHALL be set to CLEAR with busy_o=1 if CLR_ON_RST=1, else to RUN with busy_o=0.
REQ-031 Reset asserted during CLEAR or during in-flight reads SHALL discard those reads with no r_valid_o pulse; the clear SHALL restart from address 0 after release.
REQ-032 Memory contents SHALL NOT be reset when CLR_ON_RST=0.

Verification (DW=32, AW=4, MEM_NUM=12)
REQ-033 CLR_ON_RST=1, release reset: busy_o high for exactly 12 cycles, then 0; a read of any address 0..11 returns 0x00000000.
REQ-034 OUT_REG=0: write 0xDEADBEEF to address 3 with strobe 1111, read address 3 in the next cycle -> 0xDEADBEEF with r_valid_o one cycle after the read.
REQ-035 Memory[5]=0x11223344; same cycle write 0xAABBCCDD with strobe 0101 to address 5 and read address 5 -> 0x11BB33DD; a later read of address 5 -> 0x11BB33DD.
REQ-036 OUT_REG=1: reads of addresses 0,1,2 in three consecutive cycles -> three r_valid_o pulses in cycles N+2..N+4, data in order.
REQ-037 Write to address 13 then read address 13 -> 0x00000000 with r_valid_o, and addresses 0..11 unchanged.
REQ-038 Assert rst_n=0 one cycle after a read request with OUT_REG=1 -> no r_valid_o pulse, r_data_o=0.
